// File: rtl/regfile_sequencer.sv
// regfile_sequencer: command-driven controller for a 2**AW x DW register file.
// Every command gets exactly one response, and only one command is in flight at a time.
module regfile_sequencer #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_src,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [DW-1:0] rf_din,
    output logic          rf_crw,
    output logic [AW-1:0] rf_a_write,
    output logic          rf_en_decode,
    output logic [AW-1:0] rf_a_read,
    output logic          rf_en_tri,
    input  logic [DW-1:0] rf_dout
);
    typedef enum logic [3:0] {IDLE, WR, RD, MV_RD, MV_WR, SW_RA, SW_RB, SW_WA, SW_WB, CL, RSP} state_t;

    state_t        state, state_n;
    logic [AW-1:0] dst, src, cnt;
    logic [DW-1:0] data, tmp_a, tmp_b;
    logic          accept;

    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = (state == RSP);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (accept)
                       case (cmd_op)
                           3'd1:    state_n = WR;
                           3'd2:    state_n = RD;
                           3'd3:    state_n = MV_RD;
                           3'd4:    state_n = SW_RA;
                           3'd5:    state_n = CL;
                           default: state_n = RSP;
                       endcase
            WR, RD, MV_WR, SW_WB: state_n = RSP;
            MV_RD: state_n = MV_WR;
            SW_RA: state_n = SW_RB;
            SW_RB: state_n = SW_WA;
            SW_WA: state_n = SW_WB;
            CL:    state_n = (&cnt) ? RSP : CL;
            RSP:   state_n = rsp_ready ? IDLE : RSP;
            default: state_n = IDLE;
        endcase
    end

    // All file controls are decoded from state so reset forces them low immediately.
    always_comb begin
        rf_en_decode = 1'b0;
        rf_a_write   = '0;
        rf_din       = '0;
        rf_en_tri    = 1'b0;
        rf_a_read    = '0;
        case (state)
            WR:    begin rf_en_decode = 1'b1; rf_a_write = dst; rf_din = data;  end
            MV_WR: begin rf_en_decode = 1'b1; rf_a_write = dst; rf_din = tmp_a; end
            SW_WA: begin rf_en_decode = 1'b1; rf_a_write = src; rf_din = tmp_b; end
            SW_WB: begin rf_en_decode = 1'b1; rf_a_write = dst; rf_din = tmp_a; end
            CL:    begin rf_en_decode = 1'b1; rf_a_write = cnt; end
            RD, MV_RD, SW_RA: begin rf_en_tri = 1'b1; rf_a_read = src; end
            SW_RB: begin rf_en_tri = 1'b1; rf_a_read = dst; end
            default: ;
        endcase
        rf_crw = rf_en_decode;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            dst       <= '0;
            src       <= '0;
            data      <= '0;
            tmp_a     <= '0;
            tmp_b     <= '0;
            cnt       <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            cmd_ready <= (state_n == IDLE);
            if (state == IDLE && accept) begin
                dst      <= cmd_dst;
                src      <= cmd_src;
                data     <= cmd_data;
                rsp_data <= '0;
                rsp_err  <= cmd_op[2] & cmd_op[1];
            end
            case (state)
                WR:    rsp_data <= data;
                RD:    rsp_data <= rf_dout;
                MV_RD: tmp_a    <= rf_dout;
                MV_WR: rsp_data <= tmp_a;
                SW_RA: tmp_a    <= rf_dout;
                SW_RB: tmp_b    <= rf_dout;
                SW_WB: rsp_data <= tmp_a;
                CL:    cnt      <= cnt + 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: directed vectors against a behavioural 4x8 register file.
module tb_regfile_sequencer;
    logic       clk = 0, clr = 0;
    logic       cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 0, rsp_err;
    logic [2:0] cmd_op = 0;
    logic [1:0] cmd_dst = 0, cmd_src = 0, rf_a_write, rf_a_read;
    logic [7:0] cmd_data = 0, rsp_data, rf_din, rf_dout;
    logic       rf_crw, rf_en_decode, rf_en_tri;
    logic [7:0] mem [4];

    int n_chk = 0, n_err = 0;
    int lat, n_tri, n_dec;
    logic [7:0] rd;
    logic       re;
    logic [1:0] last_ar;
    logic [1:0] wlog [$];

    regfile_sequencer dut (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src(cmd_src), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .rf_din(rf_din), .rf_crw(rf_crw), .rf_a_write(rf_a_write), .rf_en_decode(rf_en_decode),
        .rf_a_read(rf_a_read), .rf_en_tri(rf_en_tri), .rf_dout(rf_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_en_decode && rf_crw) mem[rf_a_write] <= rf_din;
    assign rf_dout = rf_en_tri ? mem[rf_a_read] : 8'h00;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] src,
                           input logic [7:0] data, input int hold);
        int w = 0;
        while (!cmd_ready && w < 20) begin tick(); w++; end
        if (!cmd_ready) check("cmd_ready_timeout", 0, 1);
        cmd_op = op; cmd_dst = dst; cmd_src = src; cmd_data = data; cmd_valid = 1;
        tick();
        cmd_valid = 0;
        lat = 1; n_tri = 0; n_dec = 0; wlog.delete();
        while (lat < 40) begin
            if (rf_en_tri) begin n_tri++; last_ar = rf_a_read; end
            if (rf_en_decode && rf_crw) begin n_dec++; wlog.push_back(rf_a_write); end
            if (rsp_valid) break;
            tick();
            lat++;
        end
        if (!rsp_valid) check("rsp_timeout", 0, 1);
        rd = rsp_data;
        re = rsp_err;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_rsp_valid", rsp_valid, 1);
            check("hold_cmd_ready", cmd_ready, 0);
            check("hold_rsp_err", rsp_err, 1);
        end
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

    initial begin
        #2;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_enables", {rf_crw, rf_en_decode, rf_en_tri}, 0);
        check("rst_buses", {rf_din, rf_a_write, rf_a_read, rsp_data, rsp_err}, 0);
        tick();
        clr = 1;
        check("ready_before_edge", cmd_ready, 0);
        tick();
        check("ready_after_release", cmd_ready, 1);

        // 1: write
        run_cmd(3'd1, 2'd2, 2'd0, 8'hA5, 0);
        check("wr_lat", lat, 2);
        check("wr_data", rd, 8'hA5);
        check("wr_ndec", n_dec, 1);
        check("wr_addr", wlog[0], 2);
        check("wr_tri", n_tri, 0);
        check("wr_mem", mem[2], 8'hA5);
        check("wr_ready_back", cmd_ready, 1);

        // 2: read back
        run_cmd(3'd1, 2'd1, 2'd0, 8'h3C, 0);
        run_cmd(3'd2, 2'd0, 2'd1, 8'h00, 0);
        check("rd_lat", lat, 2);
        check("rd_ntri", n_tri, 1);
        check("rd_addr", last_ar, 1);
        check("rd_data", rd, 8'h3C);
        check("rd_err", re, 0);
        check("rd_ndec", n_dec, 0);

        // 3: swap
        run_cmd(3'd1, 2'd0, 2'd0, 8'h11, 0);
        run_cmd(3'd1, 2'd3, 2'd0, 8'hEE, 0);
        run_cmd(3'd4, 2'd3, 2'd0, 8'h00, 0);
        check("sw_lat", lat, 5);
        check("sw_data", rd, 8'h11);
        check("sw_ntri", n_tri, 2);
        check("sw_ndec", n_dec, 2);
        run_cmd(3'd2, 2'd0, 2'd0, 8'h00, 0);
        check("sw_r0", rd, 8'hEE);
        run_cmd(3'd2, 2'd0, 2'd3, 8'h00, 0);
        check("sw_r3", rd, 8'h11);

        // 4: clear-all then move
        for (int i = 0; i < 4; i++) run_cmd(3'd1, 2'(i), 2'd0, 8'(i + 1), 0);
        run_cmd(3'd5, 2'd0, 2'd0, 8'h00, 0);
        check("cl_lat", lat, 5);
        check("cl_data", rd, 8'h00);
        check("cl_ndec", n_dec, 4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) check("cl_addr", wlog[i], 32'(i));
        for (int i = 0; i < 4; i++) begin
            run_cmd(3'd2, 2'd0, 2'(i), 8'h00, 0);
            check("cl_read", rd, 8'h00);
        end
        run_cmd(3'd1, 2'd2, 2'd0, 8'h77, 0);
        run_cmd(3'd3, 2'd1, 2'd2, 8'h00, 0);
        check("mv_lat", lat, 3);
        check("mv_data", rd, 8'h77);
        run_cmd(3'd2, 2'd0, 2'd1, 8'h00, 0);
        check("mv_r1", rd, 8'h77);
        run_cmd(3'd4, 2'd2, 2'd2, 8'h00, 0);
        check("sw_same_data", rd, 8'h77);
        check("sw_same_mem", mem[2], 8'h77);

        // 5: illegal opcode with response back-pressure
        run_cmd(3'd7, 2'd1, 2'd1, 8'hFF, 3);
        check("ill_lat", lat, 1);
        check("ill_err", re, 1);
        check("ill_data", rd, 8'h00);
        check("ill_ndec", n_dec, 0);
        check("ill_ntri", n_tri, 0);
        check("ill_r1", mem[1], 8'h77);
        run_cmd(3'd0, 2'd0, 2'd0, 8'h00, 0);
        check("nop_lat", lat, 1);
        check("nop_err", re, 0);

        // 6: reset after the first swap write has landed
        run_cmd(3'd1, 2'd0, 2'd0, 8'hAA, 0);
        run_cmd(3'd1, 2'd1, 2'd0, 8'hBB, 0);
        cmd_op = 3'd4; cmd_src = 2'd0; cmd_dst = 2'd1; cmd_valid = 1;
        tick();
        cmd_valid = 0;
        tick();
        tick();
        check("swa_addr", rf_a_write, 0);
        check("swa_din", rf_din, 8'hBB);
        tick();
        clr = 0;
        #1;
        check("arst_enables", {rf_crw, rf_en_decode, rf_en_tri}, 0);
        check("arst_buses", {rf_din, rf_a_write, rf_a_read}, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_cmd_ready", cmd_ready, 0);
        tick();
        tick();
        check("arst_hold_valid", rsp_valid, 0);
        check("arst_src", mem[0], 8'hBB);
        check("arst_dst", mem[1], 8'hBB);
        clr = 1;
        tick();
        check("arst_ready_back", cmd_ready, 1);
        run_cmd(3'd2, 2'd0, 2'd0, 8'h00, 0);
        check("arst_read_r0", rd, 8'hBB);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
